// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_e  : FSM state encoding, also visible on the transmitter's debug port
//   PAT_1010 : default 4-bit pattern, matching what the 1010 detectors look for
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] PAT_1010 = 4'b1010;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in / serial-out shift register.
//   clk, reset_n : clock, asynchronous active-low reset
//   load         : capture par_in (has priority over shift_en)
//   shift_en     : shift left by one, filling with 0
//   par_in       : parallel load value
//   ser_out      : current MSB of the register
module seq_piso_shift #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [PAT_W-1:0] par_in,
  output logic             ser_out
);

  logic [PAT_W-1:0] shreg_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q <= '0;
    end else if (load) begin
      shreg_q <= par_in;
    end else if (shift_en) begin
      shreg_q <= {shreg_q[PAT_W-2:0], 1'b0};
    end
  end

  assign ser_out = shreg_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter. A start request in IDLE latches a pattern, a
// repeat count and a gap length, then sends the pattern MSB-first one bit per
// clock, repeat_cnt times, with gap_cycles idle bit-times between repetitions,
// and finally pulses done for one cycle.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : burst request, level-sampled only while in IDLE (no ready;
//                  a request outside IDLE is simply dropped)
//   abort        : synchronous abort to IDLE, beats start and everything else
//   pattern_in   : pattern to send, MSB first
//   repeat_cnt   : number of repetitions (0 gives a done pulse and no bits)
//   gap_cycles   : idle bit-times between repetitions
//   out, valid   : serial data and its qualifier (out is 0 when valid is 0)
//   busy         : high in SHIFT and GAP
//   done         : one-cycle pulse after the last bit of a burst
//   state_dbg    : current FSM state
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap_cycles,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             piso_load, piso_shift, piso_out;
  logic [PAT_W-1:0] piso_in;

  // The MSB of each repetition goes straight into out_q; the shift register
  // holds the remaining bits, already advanced by one, so its MSB is always
  // the next bit to send.
  seq_piso_shift #(.PAT_W(PAT_W)) u_piso (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (piso_load),
    .shift_en (piso_shift),
    .par_in   (piso_in),
    .ser_out  (piso_out)
  );

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    gcnt_d     = gcnt_q;
    idx_d      = idx_q;
    out_d      = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_in    = {pat_q[PAT_W-2:0], 1'b0};

    if (abort) begin
      state_d = IDLE;
      rep_d   = '0;
      gcnt_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pat_d = pattern_in;
            rep_d = repeat_cnt;
            gap_d = gap_cycles;
            if (repeat_cnt == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = SHIFT;
              out_d     = pattern_in[PAT_W-1];
              valid_d   = 1'b1;
              busy_d    = 1'b1;
              idx_d     = IDX_MAX;
              piso_load = 1'b1;
              piso_in   = {pattern_in[PAT_W-2:0], 1'b0};
            end
          end
        end
        SHIFT: begin
          if (idx_q != '0) begin
            out_d      = piso_out;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
            idx_d      = idx_q - 1'b1;
            piso_shift = 1'b1;
          end else if (rep_q > CNT_ONE) begin
            // LSB just sent and more repetitions remain.
            rep_d  = rep_q - CNT_ONE;
            busy_d = 1'b1;
            if (gap_q == '0) begin
              out_d     = pat_q[PAT_W-1];
              valid_d   = 1'b1;
              idx_d     = IDX_MAX;
              piso_load = 1'b1;
            end else begin
              state_d = GAP;
              gcnt_d  = gap_q;
            end
          end else begin
            rep_d   = '0;
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        GAP: begin
          busy_d = 1'b1;
          // gcnt_q counts the gap cycles still to spend, this one included.
          if (gcnt_q <= CNT_ONE) begin
            state_d   = SHIFT;
            gcnt_d    = '0;
            out_d     = pat_q[PAT_W-1];
            valid_d   = 1'b1;
            idx_d     = IDX_MAX;
            piso_load = 1'b1;
          end else begin
            gcnt_d = gcnt_q - CNT_ONE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
